spi_wb_bridge: RTL

SPI_WB_BRIDGE -- requirements
Module: spi_wb_bridge

---
 rtl/spi_wb_bridge_if.sv | 31 +++
 rtl/spi_wb_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge_if.sv
// Byte-stream side (SPI shift-register handshake) and pipelined Wishbone master
// side of the SPI-to-Wishbone bridge, bundled so the top level carries one port.
interface spi_wb_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 16
);
    logic [7:0]      rx_data;
    logic            rx_stb;
    logic [7:0]      tx_data;
    logic            tx_stb;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [DW/8-1:0] wb_sel;
    logic [AW-1:0]   wb_adr;
    logic [DW-1:0]   wb_dat_w;
    logic [DW-1:0]   wb_dat_r;
    logic            wb_stall;
    logic            wb_ack;
    logic            wb_err;

    modport master (
        input  rx_data, rx_stb, wb_dat_r, wb_stall, wb_ack, wb_err,
        output tx_data, tx_stb, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w
    );

    modport slave (
        output rx_data, rx_stb, wb_dat_r, wb_stall, wb_ack, wb_err,
        input  tx_data, tx_stb, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w
    );
endinterface

// File: rtl/spi_wb_bridge.sv
// Turns framed SPI bytes (cmd, address, count, data) into pipelined Wishbone
// cycles, answering every received byte with exactly one transmit byte.
module spi_wb_bridge #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    spi_wb_bridge_if.master bus
);
    localparam int NB = DW / 8;
    localparam int NA = (AW + 7) / 8;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, COUNT, WDATA, WAIT, RDATA} state_t;

    state_t        state, state_next;
    logic          we, inc;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w, rd_word;
    logic [7:0]    word_cnt;
    logic [2:0]    byte_cnt;
    logic          cyc, stb, done, failed;
    logic [TW-1:0] timer;
    logic [7:0]    tx_data_r;
    logic          tx_stb_r;

    logic [7:0]    tx_next;
    logic          latch_cmd, shift_adr, latch_cnt, shift_wr, shift_rd;
    logic          start, next_word, byte_clr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Every decision is taken on a received byte; the response byte goes out next cycle.
    always_comb begin
        state_next = state;
        tx_next    = 8'h00;
        latch_cmd  = 1'b0;
        shift_adr  = 1'b0;
        latch_cnt  = 1'b0;
        shift_wr   = 1'b0;
        shift_rd   = 1'b0;
        start      = 1'b0;
        next_word  = 1'b0;
        byte_clr   = 1'b0;
        if (bus.rx_stb) begin
            case (state)
                IDLE: begin
                    if (bus.rx_data != 8'h00 && bus.rx_data[5:4] == 2'b00) begin
                        latch_cmd  = 1'b1;
                        byte_clr   = 1'b1;
                        state_next = ADDR;
                    end
                end
                ADDR: begin
                    shift_adr = 1'b1;
                    if (byte_cnt == 3'(NA - 1)) begin
                        byte_clr   = 1'b1;
                        state_next = COUNT;
                    end
                end
                COUNT: begin
                    latch_cnt = 1'b1;
                    byte_clr  = 1'b1;
                    if (we) begin
                        state_next = WDATA;
                    end else begin
                        start      = 1'b1;
                        state_next = WAIT;
                    end
                end
                WDATA: begin
                    shift_wr = 1'b1;
                    if (byte_cnt == 3'(NB - 1)) begin
                        byte_clr   = 1'b1;
                        start      = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (!cyc && done) begin
                        byte_clr = 1'b1;
                        if (failed) begin
                            tx_next    = 8'hEE;
                            state_next = IDLE;
                        end else begin
                            tx_next = 8'hFF;
                            if (!we) begin
                                state_next = RDATA;
                            end else if (word_cnt != 8'd0) begin
                                next_word  = 1'b1;
                                state_next = WDATA;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
                RDATA: begin
                    tx_next  = rd_word[DW-1 -: 8];
                    shift_rd = 1'b1;
                    if (byte_cnt == 3'(NB - 1)) begin
                        byte_clr = 1'b1;
                        if (word_cnt != 8'd0) begin
                            next_word  = 1'b1;
                            start      = 1'b1;
                            state_next = WAIT;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and Wishbone cycle tracking; a started cycle closes on ack, err or timer expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            we        <= 1'b0;
            inc       <= 1'b0;
            sel       <= 4'h0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            done      <= 1'b0;
            failed    <= 1'b0;
            timer     <= '0;
            word_cnt  <= 8'd0;
            byte_cnt  <= 3'd0;
            tx_stb_r  <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            tx_stb_r <= bus.rx_stb;
            if (bus.rx_stb) tx_data_r <= tx_next;
            if (latch_cmd) begin
                we  <= bus.rx_data[7];
                inc <= bus.rx_data[6];
                sel <= bus.rx_data[3:0];
            end
            if (byte_clr)
                byte_cnt <= 3'd0;
            else if (shift_adr || shift_wr || shift_rd)
                byte_cnt <= byte_cnt + 3'd1;
            if (shift_adr) adr <= AW'({adr, bus.rx_data});
            if (shift_wr)  dat_w <= DW'({dat_w, bus.rx_data});
            if (shift_rd)  rd_word <= rd_word << 8;
            if (latch_cnt) word_cnt <= bus.rx_data;
            if (next_word) begin
                word_cnt <= word_cnt - 8'd1;
                if (inc) adr <= adr + AW'(1);
            end
            if (start) begin
                cyc    <= 1'b1;
                stb    <= 1'b1;
                timer  <= '0;
                done   <= 1'b0;
                failed <= 1'b0;
            end else if (cyc) begin
                timer <= timer + TW'(1);
                if (stb && !bus.wb_stall) stb <= 1'b0;
                if (bus.wb_ack || bus.wb_err) begin
                    cyc    <= 1'b0;
                    stb    <= 1'b0;
                    done   <= 1'b1;
                    failed <= bus.wb_err;
                    if (bus.wb_ack && !bus.wb_err && !we) rd_word <= bus.wb_dat_r;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    cyc    <= 1'b0;
                    stb    <= 1'b0;
                    done   <= 1'b1;
                    failed <= 1'b1;
                end
            end
        end
    end

    assign bus.tx_data  = tx_data_r;
    assign bus.tx_stb   = tx_stb_r;
    assign bus.wb_cyc   = cyc;
    assign bus.wb_stb   = stb;
    assign bus.wb_we    = we;
    assign bus.wb_sel   = sel[NB-1:0];
    assign bus.wb_adr   = adr;
    assign bus.wb_dat_w = dat_w;
endmodule
